vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
- Sequencing controller for the vending machine datapath.
- Accumulates inserted coins into a 4-bit credit (0-15 NIS) and holds a writable per-item 4-bit price table.
- Accepts item selections and issues one-cycle dispense and change commands.
- Sits between the coin acceptor / keypad front end and the dispense/change actuators; all prices and amounts use the team's 4-bit unsigned price encoding.

Parameters:
- NUM_ITEMS, 4, number of selectable items; item index width is clog2(NUM_ITEMS).
- MAX_CREDIT, 15, credit ceiling in NIS; must be <= 15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  one-cycle strobe: coin inserted.
- coin_value  in  4  coin value in NIS; legal values are 1, 2, 5, 10.
- sel_valid  in  1  one-cycle strobe: item selected.
- sel_item  in  clog2(NUM_ITEMS)  selected item index.
- cancel  in  1  one-cycle strobe: abort transaction and refund.
- price_wr_en  in  1  price table write strobe.
- price_wr_item  in  clog2(NUM_ITEMS)  price table write index.
- price_wr_data  in  4  new price in NIS; 0 = item disabled.
- credit  out  4  current accumulated credit.
- busy  out  1  high in DISPENSE or CHANGE.
- coin_reject  out  1  one-cycle pulse: coin returned unaccepted.
- sel_error  out  1  one-cycle pulse: selection refused.
- dispense_valid  out  1  one-cycle pulse: release item.
- dispense_item  out  clog2(NUM_ITEMS)  item to release; valid with dispense_valid.
- change_valid  out  1  one-cycle pulse: pay out change.
- change_amount  out  4  change in NIS; valid with change_valid, else 0.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-transaction):
  - state = IDLE; credit = 0; all pulse outputs = 0; dispense_item = 0; change_amount = 0.
  - Price table loads the package defaults.
  - A reset during DISPENSE or CHANGE aborts the transaction: no pulse is emitted and credit is lost.
- States: IDLE (credit = 0), COLLECT (credit > 0), DISPENSE, CHANGE.
- Input priority per cycle in IDLE/COLLECT: cancel > sel_valid > coin_valid. A lower-priority strobe in the same cycle is dropped; a dropped coin produces coin_reject.
- Coin handling:
  - Accepted if coin_value is in {1,2,5,10} and credit + coin_value <= MAX_CREDIT. Use a 5-bit sum; no wrap-around.
  - Otherwise coin_reject pulses the next cycle and credit is unchanged.
  - Accepted coin at cycle N: credit updated at N+1; IDLE -> COLLECT.
- Selection (latch price[sel_item] in the selection cycle):
  - If price == 0 or price > credit: sel_error at N+1; state and credit unchanged.
  - Otherwise at N+1: state = DISPENSE, dispense_valid = 1, dispense_item = sel_item, credit = credit - price.
  - Following cycle: if the remaining credit > 0, go to CHANGE. Otherwise go to IDLE.
- CHANGE (one cycle): change_valid = 1, change_amount = credit, credit = 0; then IDLE.
- Cancel:
  - In COLLECT: go directly to CHANGE with full credit, with no dispense.
  - In IDLE: no effect.
- While busy:
  - coin_valid -> coin_reject next cycle.
  - sel_valid and cancel are ignored, with no sel_error.
- Price writes:
  - Accepted in any state; the new price is visible from the next cycle.
  - A write to the item being selected in the same cycle: the selection uses the old price.
- Exact-price purchase: dispense only, no change pulse. IDLE reached 2 cycles after selection.
- All outputs are registered.

Decomposition:
- Package vend_pkg holds:
  - state enum (IDLE, COLLECT, DISPENSE, CHANGE);
  - price_t (4-bit unsigned);
  - legal coin constants COIN_1, COIN_2, COIN_5, COIN_10;
  - DEFAULT_PRICES array {3, 5, 7, 12}.
- One natural sub-module: vend_price_table, a register file with a synchronous write port and a combinational read port, reset to the defaults.

Test Plan:
- Reset, insert coins 5 then 2, select item 1 (price 5): credit reads 5 then 7; dispense_valid with item 1 one cycle after the select; next cycle change_valid with amount 2; credit 0; back in IDLE.
- Insert 10, then 10 again: second coin produces coin_reject; credit stays 10. Insert coin value 3: coin_reject; credit stays 10.
- Credit 2, select item 2 (price 7): sel_error pulses, credit stays 2. Then cancel: change_valid with amount 2, no dispense.
- Write price 0 to item 0, then select item 0 with credit 5: sel_error. Write price 5 to item 0, select again: dispense with no change pulse.
- Credit 5, assert coin 2 and sel item 1 in the same cycle: dispense item 1, coin_reject, change_amount 0 (no change pulse). Assert coin during DISPENSE: coin_reject.
- Credit 7, select item 0, assert rst in the DISPENSE cycle: no change pulse; credit 0; prices restored to defaults {3, 5, 7, 12}.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine controller slice.
// Prices, coins and credit all use the 4-bit unsigned NIS encoding.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE
    } state_t;

    typedef logic [3:0] price_t;

    localparam price_t COIN_1  = 4'd1;
    localparam price_t COIN_2  = 4'd2;
    localparam price_t COIN_5  = 4'd5;
    localparam price_t COIN_10 = 4'd10;

    localparam int unsigned NUM_DEFAULTS = 4;
    localparam price_t DEFAULT_PRICES [NUM_DEFAULTS] = '{4'd3, 4'd5, 4'd7, 4'd12};

    // Items beyond the default table come up disabled (price 0).
    function automatic price_t default_price(input int unsigned idx);
        return (idx < NUM_DEFAULTS) ? DEFAULT_PRICES[idx[1:0]] : '0;
    endfunction

    function automatic logic legal_coin(input price_t value);
        return (value == COIN_1) || (value == COIN_2) ||
               (value == COIN_5) || (value == COIN_10);
    endfunction

endpackage

// File: rtl/vend_price_table.sv
// Per-item price register file: synchronous write, combinational read,
// reset to the package default prices.
module vend_price_table
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 4,
    parameter int unsigned IW        = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_item,
    input  price_t        wr_data,
    input  logic [IW-1:0] rd_item,
    output price_t        rd_data
);

    price_t prices [NUM_ITEMS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                prices[i] <= default_price(i);
            end
        end else if (wr_en) begin
            prices[wr_item] <= wr_data;
        end
    end

    always_comb begin
        rd_data = prices[rd_item];
    end

endmodule

// File: rtl/vend_controller.sv
// Vending machine sequencing controller: coin accumulation, item selection,
// one-cycle dispense and change commands. All outputs are registered.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned MAX_CREDIT = 15,
    localparam int unsigned IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_valid,
    input  logic [3:0]    coin_value,
    input  logic          sel_valid,
    input  logic [IW-1:0] sel_item,
    input  logic          cancel,
    input  logic          price_wr_en,
    input  logic [IW-1:0] price_wr_item,
    input  logic [3:0]    price_wr_data,
    output logic [3:0]    credit,
    output logic          busy,
    output logic          coin_reject,
    output logic          sel_error,
    output logic          dispense_valid,
    output logic [IW-1:0] dispense_item,
    output logic          change_valid,
    output logic [3:0]    change_amount
);

    localparam logic [4:0] MAX_SUM = 5'(MAX_CREDIT);

    state_t     state;
    price_t     sel_price;
    logic [4:0] coin_sum;
    logic       coin_ok;

    vend_price_table #(
        .NUM_ITEMS (NUM_ITEMS),
        .IW        (IW)
    ) u_price_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (price_wr_en),
        .wr_item (price_wr_item),
        .wr_data (price_wr_data),
        .rd_item (sel_item),
        .rd_data (sel_price)
    );

    // 5-bit sum so an overflowing coin is rejected instead of wrapping.
    always_comb begin
        coin_sum = {1'b0, credit} + {1'b0, coin_value};
        coin_ok  = legal_coin(coin_value) && (coin_sum <= MAX_SUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            credit         <= '0;
            busy           <= 1'b0;
            coin_reject    <= 1'b0;
            sel_error      <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_item  <= '0;
            change_valid   <= 1'b0;
            change_amount  <= '0;
        end else begin
            coin_reject    <= 1'b0;
            sel_error      <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_item  <= '0;
            change_valid   <= 1'b0;
            change_amount  <= '0;

            case (state)
                IDLE, COLLECT: begin
                    // cancel > select > coin; a coin losing arbitration is returned
                    if (cancel) begin
                        coin_reject <= coin_valid;
                        if (state == COLLECT) begin
                            state         <= CHANGE;
                            busy          <= 1'b1;
                            change_valid  <= 1'b1;
                            change_amount <= credit;
                            credit        <= '0;
                        end
                    end else if (sel_valid) begin
                        coin_reject <= coin_valid;
                        if (sel_price == '0 || sel_price > credit) begin
                            sel_error <= 1'b1;
                        end else begin
                            state          <= DISPENSE;
                            busy           <= 1'b1;
                            dispense_valid <= 1'b1;
                            dispense_item  <= sel_item;
                            credit         <= credit - sel_price;
                        end
                    end else if (coin_valid) begin
                        if (coin_ok) begin
                            credit <= coin_sum[3:0];
                            state  <= COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end

                DISPENSE: begin
                    coin_reject <= coin_valid;
                    if (credit != '0) begin
                        state         <= CHANGE;
                        change_valid  <= 1'b1;
                        change_amount <= credit;
                        credit        <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                CHANGE: begin
                    coin_reject <= coin_valid;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = '0;
    logic       cancel = 1'b0;
    logic       price_wr_en = 1'b0;
    logic [1:0] price_wr_item = '0;
    logic [3:0] price_wr_data = '0;

    logic [3:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       sel_error;
    logic       dispense_valid;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [3:0] change_amount;

    always #5 clk = ~clk;

    vend_controller #(
        .NUM_ITEMS  (4),
        .MAX_CREDIT (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .sel_valid      (sel_valid),
        .sel_item       (sel_item),
        .cancel         (cancel),
        .price_wr_en    (price_wr_en),
        .price_wr_item  (price_wr_item),
        .price_wr_data  (price_wr_data),
        .credit         (credit),
        .busy           (busy),
        .coin_reject    (coin_reject),
        .sel_error      (sel_error),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .change_valid   (change_valid),
        .change_amount  (change_amount)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a purchase occupies the dispense pulse cycle and, if money is
    // left over, one change cycle; outside those, credit > 0 means collecting.
    int m_credit;
    int m_price [4];
    bit m_after_dispense;
    bit m_after_change;
    int e_credit, e_busy, e_crej, e_serr, e_disp, e_item, e_chg, e_amt;

    task automatic model_step();
        int p;
        e_crej = 0; e_serr = 0; e_disp = 0; e_item = 0; e_chg = 0; e_amt = 0;
        if (rst) begin
            m_credit = 0;
            m_price = '{3, 5, 7, 12};
            m_after_dispense = 0;
            m_after_change = 0;
        end else begin
            p = m_price[sel_item];
            if (m_after_dispense) begin
                m_after_dispense = 0;
                e_crej = coin_valid;
                if (m_credit > 0) begin
                    e_chg = 1; e_amt = m_credit; m_credit = 0; m_after_change = 1;
                end
            end else if (m_after_change) begin
                m_after_change = 0;
                e_crej = coin_valid;
            end else if (cancel) begin
                e_crej = coin_valid;
                if (m_credit > 0) begin
                    e_chg = 1; e_amt = m_credit; m_credit = 0; m_after_change = 1;
                end
            end else if (sel_valid) begin
                e_crej = coin_valid;
                if (p == 0 || p > m_credit) begin
                    e_serr = 1;
                end else begin
                    e_disp = 1; e_item = sel_item; m_credit -= p; m_after_dispense = 1;
                end
            end else if (coin_valid) begin
                if ((coin_value inside {4'd1, 4'd2, 4'd5, 4'd10}) && (m_credit + coin_value <= 15))
                    m_credit += coin_value;
                else
                    e_crej = 1;
            end
            if (price_wr_en) m_price[price_wr_item] = price_wr_data;
        end
        e_credit = m_credit;
        e_busy = (m_after_dispense || m_after_change) ? 1 : 0;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("credit", credit, e_credit);
        chk("busy", busy, e_busy);
        chk("coin_reject", coin_reject, e_crej);
        chk("sel_error", sel_error, e_serr);
        chk("dispense_valid", dispense_valid, e_disp);
        if (e_disp != 0) chk("dispense_item", dispense_item, e_item);
        chk("change_valid", change_valid, e_chg);
        chk("change_amount", change_amount, e_amt);
    end

    task automatic step(input bit r, input bit cv, input int val, input bit sv, input int it,
                        input bit cn, input bit we, input int wi, input int wd);
        @(negedge clk);
        rst = r;
        coin_valid = cv;
        coin_value = 4'(val);
        sel_valid = sv;
        sel_item = 2'(it);
        cancel = cn;
        price_wr_en = we;
        price_wr_item = 2'(wi);
        price_wr_data = 4'(wd);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();            step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic coin(input int v); step(0, 1, v, 0, 0, 0, 0, 0, 0); endtask
    task automatic sel(input int i);  step(0, 0, 0, 1, i, 0, 0, 0, 0); endtask
    task automatic cxl();             step(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic wr(input int i, input int d); step(0, 0, 0, 0, 0, 0, 1, i, d); endtask

    initial begin
        int coin_tbl [12];
        int r;
        coin_tbl = '{1, 2, 5, 10, 1, 2, 5, 10, 0, 3, 7, 15};

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("lit_reset_credit", credit, 0);
        chk("lit_reset_busy", busy, 0);

        // Basic purchase with change
        coin(5);  chk("lit_credit_5", credit, 5);
        coin(2);  chk("lit_credit_7", credit, 7);
        sel(1);   chk("lit_disp_valid", dispense_valid, 1);
                  chk("lit_disp_item", dispense_item, 1);
                  chk("lit_credit_after_sel", credit, 2);
        idle();   chk("lit_chg_valid", change_valid, 1);
                  chk("lit_chg_amount", change_amount, 2);
                  chk("lit_credit_after_chg", credit, 0);
        idle();   chk("lit_idle_busy", busy, 0);

        // Overflow and illegal coins
        coin(10); chk("lit_credit_10", credit, 10);
        coin(10); chk("lit_overflow_reject", coin_reject, 1);
                  chk("lit_overflow_credit", credit, 10);
        coin(3);  chk("lit_illegal_reject", coin_reject, 1);
                  chk("lit_illegal_credit", credit, 10);
        cxl();    chk("lit_cancel_amount10", change_amount, 10);
        idle();

        // Insufficient credit, then cancel refund
        coin(2);
        sel(2);   chk("lit_sel_error", sel_error, 1);
                  chk("lit_sel_error_credit", credit, 2);
        cxl();    chk("lit_cancel_chg", change_valid, 1);
                  chk("lit_cancel_amount", change_amount, 2);
                  chk("lit_cancel_no_disp", dispense_valid, 0);
        idle();

        // Disabled item, then exact-price purchase
        wr(0, 0);
        coin(5);
        sel(0);   chk("lit_disabled_error", sel_error, 1);
        wr(0, 5);
        sel(0);   chk("lit_exact_disp", dispense_valid, 1);
                  chk("lit_exact_credit", credit, 0);
        idle();   chk("lit_exact_no_chg", change_valid, 0);
                  chk("lit_exact_idle", busy, 0);

        // Coin and select in the same cycle; coin while dispensing
        coin(5);
        step(0, 1, 2, 1, 1, 0, 0, 0, 0);
                  chk("lit_same_disp", dispense_valid, 1);
                  chk("lit_same_item", dispense_item, 1);
                  chk("lit_same_reject", coin_reject, 1);
        coin(5);  chk("lit_busy_reject", coin_reject, 1);
                  chk("lit_busy_no_chg", change_amount, 0);

        // Price write to the item being selected uses the old price
        coin(5);
        step(0, 0, 0, 1, 1, 0, 1, 1, 9);
                  chk("lit_old_price_disp", dispense_valid, 1);
                  chk("lit_old_price_credit", credit, 0);
        wr(1, 5);

        // Reset during dispense, then confirm default prices are back
        coin(5); coin(2);
        sel(0);   chk("lit_pre_rst_disp", dispense_valid, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
                  chk("lit_rst_no_chg", change_valid, 0);
                  chk("lit_rst_credit", credit, 0);
        idle();
        coin(2); coin(1);
        sel(0);   chk("lit_default0_disp", dispense_valid, 1);
                  chk("lit_default0_credit", credit, 0);
        idle();
        coin(10); coin(2);
        sel(3);   chk("lit_default3_disp", dispense_valid, 1);
                  chk("lit_default3_credit", credit, 0);
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit rr, cv, sv, cn, we;
            r  = $urandom_range(0, 99);
            rr = (r == 0);
            cv = ($urandom_range(0, 99) < 45);
            sv = ($urandom_range(0, 99) < 20);
            cn = ($urandom_range(0, 99) < 6);
            we = ($urandom_range(0, 99) < 5);
            step(rr, cv, coin_tbl[$urandom_range(0, 11)], sv, $urandom_range(0, 3), cn,
                 we, $urandom_range(0, 3), $urandom_range(0, 15));
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
